// File: rtl/lcd_msg_pkg.sv
// Shared message codes, state encoding and code validity check for the LCD
// message scheduler.
package lcd_msg_pkg;

  localparam logic [3:0] MSG_BIENVENIDO = 4'd0;
  localparam logic [3:0] MSG_PRESIONE_A = 4'd1;
  localparam logic [3:0] MSG_OPCION_B   = 4'd3;
  localparam logic [3:0] MSG_OPCION_C   = 4'd4;
  localparam logic [3:0] MSG_TIEMPO     = 4'd5;
  localparam logic [3:0] MSG_DECENAS    = 4'd6;
  localparam logic [3:0] MSG_SEGUNDOS   = 4'd7;
  localparam logic [3:0] MSG_DISFRUTE   = 4'd8;
  localparam logic [3:0] MSG_PAUSA      = 4'd9;
  localparam logic [3:0] MSG_TARJETA    = 4'd10;
  localparam logic [3:0] MSG_GASTO      = 4'd11;
  localparam logic [3:0] MSG_REINICIAR  = 4'd12;
  localparam logic [3:0] MSG_GRACIAS    = 4'd13;
  localparam logic [3:0] MSG_CONTINUAR  = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // Codes 2 and 15 have no screen text behind them.
  function automatic logic msg_is_valid(input logic [3:0] code);
    return (code != 4'd2) && (code != 4'd15);
  endfunction

endpackage

// File: rtl/lcd_prio_arb.sv
// Fixed-priority one-hot grant: the lowest-index active request wins while en is high.
module lcd_prio_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  // seen[i]: some request below index i is active
  logic [N-1:0] seen;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_arb
      assign gnt[gi] = en & req[gi] & ~seen[gi];
      if (gi < N - 1) begin : g_chain
        assign seen[gi+1] = seen[gi] | req[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Chooses the message code shown on the LCD: fixed-priority arbitration,
// minimum hold time per message and auto-revert of timed messages.
module lcd_msg_scheduler
  import lcd_msg_pkg::*;
#(
  parameter int         NREQ         = 4,
  parameter int         MIN_HOLD_CYC = 50_000_000,
  parameter int         TIMED_CYC    = 250_000_000,
  parameter logic [3:0] IDLE_MSG     = 4'd0,
  parameter int         CNT_W        = 28
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_msg,
  input  logic [NREQ-1:0]   req_timed,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        oMENSAJE,
  output logic              oBUSY,
  output logic              oCHANGE,
  output logic              oERR
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMED_LAST = CNT_W'(TIMED_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t             state_reg, state_next;
  logic [3:0]         msg_reg, msg_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               timed_reg, timed_next;
  logic               busy_reg;
  logic               change_reg, change_next;
  logic               err_reg, err_next;

  logic               accept;
  logic [3:0]         sel_msg;
  logic               sel_timed;

  lcd_prio_arb #(.N(NREQ)) u_arb (
    .req (req_valid),
    .en  (state_reg != ST_HOLD),
    .gnt (req_ready)
  );

  // Grant is one-hot, so OR-ing the masked fields selects the winner.
  always_comb begin
    sel_msg   = 4'd0;
    sel_timed = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_msg   = sel_msg | req_msg[4*i +: 4];
        sel_timed = sel_timed | req_timed[i];
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_next  = state_reg;
    msg_next    = msg_reg;
    cnt_next    = cnt_reg;
    timed_next  = timed_reg;
    change_next = 1'b0;
    err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: cnt_next = '0;
      ST_HOLD: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == HOLD_LAST) state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (timed_reg && cnt_reg == TIMED_LAST) begin
          state_next  = ST_IDLE;
          msg_next    = IDLE_MSG;
          cnt_next    = '0;
          timed_next  = 1'b0;
          change_next = (msg_reg != IDLE_MSG);
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A valid acceptance overrides any revert decided above; an undefined
    // code is consumed without disturbing the running display state.
    if (accept) begin
      if (msg_is_valid(sel_msg)) begin
        state_next  = ST_HOLD;
        msg_next    = sel_msg;
        cnt_next    = '0;
        timed_next  = sel_timed;
        change_next = (sel_msg != msg_reg);
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg  <= ST_IDLE;
      msg_reg    <= IDLE_MSG;
      cnt_reg    <= '0;
      timed_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      change_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      msg_reg    <= msg_next;
      cnt_reg    <= cnt_next;
      timed_reg  <= timed_next;
      busy_reg   <= (state_next == ST_HOLD);
      change_reg <= change_next;
      err_reg    <= err_next;
    end
  end

  assign oMENSAJE = msg_reg;
  assign oBUSY    = busy_reg;
  assign oCHANGE  = change_reg;
  assign oERR     = err_reg;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Bench for lcd_msg_scheduler: directed scenarios plus random traffic, all
// checked against an age-based behavioural model of the display rules.
module tb_lcd_msg_scheduler;

  localparam int         NREQ     = 4;
  localparam int         MIN_HOLD = 4;
  localparam int         TIMED    = 10;
  localparam logic [3:0] IDLE     = 4'd0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_msg;
  logic [NREQ-1:0]   req_timed;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        mensaje;
  logic              busy, change, err;

  always #5 clk = ~clk;

  lcd_msg_scheduler #(
    .NREQ(NREQ), .MIN_HOLD_CYC(MIN_HOLD), .TIMED_CYC(TIMED),
    .IDLE_MSG(IDLE), .CNT_W(28)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .req_valid(req_valid), .req_msg(req_msg), .req_timed(req_timed),
    .req_ready(req_ready),
    .oMENSAJE(mensaje), .oBUSY(busy), .oCHANGE(change), .oERR(err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: what is shown, whether a message is active, and edges since it was accepted.
  logic [3:0] m_msg = IDLE;
  bit         m_active = 0;
  bit         m_timed = 0;
  int         m_age = 0;
  bit         m_change = 0;
  bit         m_err = 0;

  // Requester-side pending requests.
  bit         pend [NREQ];
  logic [3:0] p_msg [NREQ];
  bit         p_timed [NREQ];

  function automatic bit code_ok(input logic [3:0] c);
    return (c != 4'd2) && (c != 4'd15);
  endfunction

  function automatic int exp_grant();
    if (m_active && m_age < MIN_HOLD) return -1;
    for (int i = 0; i < NREQ; i++) if (pend[i]) return i;
    return -1;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_msg[4*i +: 4]  = p_msg[i];
      req_timed[i]       = p_timed[i];
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] code, input bit timed);
    pend[idx]    = 1'b1;
    p_msg[idx]   = code;
    p_timed[idx] = timed;
    apply_inputs();
  endtask

  task automatic model_reset();
    m_msg = IDLE; m_active = 0; m_timed = 0; m_age = 0; m_change = 0; m_err = 0;
  endtask

  task automatic check_outputs();
    chk("mensaje", mensaje, m_msg);
    chk("busy", busy, m_active && m_age < MIN_HOLD);
    chk("change", change, m_change);
    chk("err", err, m_err);
  endtask

  task automatic step(input bit rnd);
    int         g;
    logic [3:0] exp_ready;
    logic [3:0] pick;
    @(negedge clk);
    g = exp_grant();
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk);
    m_change = 0;
    m_err    = 0;
    if (m_active) m_age++;
    if (g >= 0 && code_ok(p_msg[g])) begin
      m_change = (p_msg[g] != m_msg);
      m_msg    = p_msg[g];
      m_active = 1;
      m_timed  = p_timed[g];
      m_age    = 0;
    end else begin
      if (g >= 0) m_err = 1;
      if (m_active && m_timed && m_age == TIMED) begin
        m_change = (m_msg != IDLE);
        m_msg    = IDLE;
        m_active = 0;
        m_timed  = 0;
      end
    end
    #1;
    check_outputs();
    if (g >= 0) pend[g] = 1'b0;
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 9) == 0) pick = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd15;
          else begin
            pick = 4'($urandom_range(0, 13));
            if (pick >= 4'd2) pick = pick + 4'd1;
          end
          pend[i]    = 1'b1;
          p_msg[i]   = pick;
          p_timed[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    apply_inputs();
  endtask

  task automatic run(input int n, input bit rnd);
    for (int k = 0; k < n; k++) step(rnd);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_msg[i] = 4'd0; p_timed[i] = 1'b0;
    end
    apply_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mensaje", mensaje, IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(20, 0);                               // quiet after reset
    set_req(1, 4'd5, 1'b0);  run(100, 0);     // persistent message stays
    set_req(0, 4'd9, 1'b1);
    set_req(2, 4'd3, 1'b0);  run(30, 0);      // priority, then hold release
    set_req(1, 4'd13, 1'b1); run(15, 0);      // timed revert
    set_req(1, 4'd13, 1'b1); run(10, 0);      // accept, then nine more edges
    set_req(2, 4'd8, 1'b0);  run(6, 0);       // new request lands in expiry cycle
    set_req(0, 4'd2, 1'b0);  run(3, 0);
    set_req(0, 4'd15, 1'b0); run(6, 0);       // undefined codes

    set_req(3, 4'd7, 1'b0);  run(2, 0);       // now mid-HOLD
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_mensaje", mensaje, IDLE);
    chk("arst_busy", busy, 1'b0);
    chk("arst_change", change, 1'b0);
    chk("arst_ready", req_ready, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
